// File: rtl/qc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qc_pkg
//  Description : Shared types for the quantum-circuit core: gate opcodes,
//                packed gate word, loader FSM states and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package qc_pkg;

    // Qubit index width; a single-qubit core still needs one index bit
    function automatic int calc_qw(input int n_qubits);
        return (n_qubits > 1) ? $clog2(n_qubits) : 1;
    endfunction

    // Gate word width: 4-bit opcode plus control and target indices
    function automatic int calc_gw(input int n_qubits);
        return 4 + 2 * calc_qw(n_qubits);
    endfunction

    localparam int c_qc_n_qubits = 4;
    localparam int c_qc_qw       = calc_qw(c_qc_n_qubits);

    typedef enum logic [3:0] {
        OP_I    = 4'd0,
        OP_X    = 4'd1,
        OP_Y    = 4'd2,
        OP_Z    = 4'd3,
        OP_H    = 4'd4,
        OP_S    = 4'd5,
        OP_T    = 4'd6,
        OP_CNOT = 4'd7
    } gate_op_e;

    // Gate word layout shared by the loader and the scheduler
    typedef struct packed {
        gate_op_e               op;
        logic [c_qc_qw-1:0]     ctrl;
        logic [c_qc_qw-1:0]     tgt;
    } gate_t;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_ARM       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/gate_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_loader_if
//  Description : Host-side load stream, scheduler-side gate stream and
//                status signals of the gate loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_loader_if
    import qc_pkg::*;
#(
    parameter int N_QUBITS = 4,
    parameter int DEPTH    = 32
) ();
    localparam int c_gw  = calc_gw(N_QUBITS);
    localparam int c_plw = $clog2(DEPTH) + 1;

    // host load stream
    logic               in_valid;
    logic               in_ready;
    logic [c_gw-1:0]    in_gate;
    logic               in_last;
    logic               clear;

    // scheduler side
    logic               sched_start;
    logic               g_valid;
    logic               g_ready;
    logic [c_gw-1:0]    g_data;
    logic               g_last;
    logic               sched_done;

    // status
    logic [c_plw-1:0]   prog_len;
    logic               busy;
    logic               prog_done;
    logic               err_ovf;
    logic               err_early;

    // Loader view
    modport slave (
        input  in_valid, in_gate, in_last, clear, g_ready, sched_done,
        output in_ready, sched_start, g_valid, g_data, g_last,
               prog_len, busy, prog_done, err_ovf, err_early
    );

    // Host / scheduler view
    modport master (
        output in_valid, in_gate, in_last, clear, g_ready, sched_done,
        input  in_ready, sched_start, g_valid, g_data, g_last,
               prog_len, busy, prog_done, err_ovf, err_early
    );

endinterface
`default_nettype wire

// File: rtl/gate_loader_mem.sv
`default_nettype none
// ============================================================================
//  Module      : gate_mem
//  Description : DEPTH x GW program store, one synchronous write port and
//                one asynchronous read port; contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_mem #(
    parameter int DEPTH = 32,
    parameter int GW    = 8
) (
    input  wire logic                       clk,
    input  wire logic                       we_i,
    input  wire logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  wire logic [GW-1:0]              wdata_i,
    input  wire logic [$clog2(DEPTH)-1:0]   raddr_i,
    output      logic [GW-1:0]              rdata_o
);

    logic [GW-1:0] mem_q [DEPTH];

    // Write port: store one gate word per accepted host beat
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/gate_loader.sv
`default_nettype none
// ============================================================================
//  Module      : gate_loader
//  Description : Buffers a gate program from the host, pulses the scheduler
//                start, streams the stored gates and holds completion status
//                until the host clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_loader
    import qc_pkg::*;
#(
    parameter int N_QUBITS = 4,
    parameter int DEPTH    = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    gate_loader_if.slave    bus
);

    localparam int                  c_gw        = calc_gw(N_QUBITS);
    localparam int                  c_aw        = $clog2(DEPTH);
    localparam int                  c_plw       = c_aw + 1;
    localparam logic [c_aw-1:0]     c_last_addr = c_aw'(DEPTH - 1);
    localparam logic [c_aw-1:0]     c_ptr_one   = c_aw'(1);
    localparam logic [c_plw-1:0]    c_len_one   = c_plw'(1);

    loader_state_e      state_q;
    logic [c_aw-1:0]    wr_ptr_q;
    logic [c_aw-1:0]    rd_ptr_q;
    logic [c_plw-1:0]   prog_len_q;
    logic               err_ovf_q;
    logic               err_early_q;

    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_full;
    logic               w_g_valid;
    logic               w_g_last;
    logic               w_g_fire;
    logic [c_gw-1:0]    w_rd_data;

    // in_ready is forced low while reset is held so no beat is taken then
    assign w_in_ready = (state_q == ST_LOAD) && !rst;
    // clear in LOAD wins over a word offered in the same cycle
    assign w_in_fire  = bus.in_valid && w_in_ready && !bus.clear;
    assign w_full     = (wr_ptr_q == c_last_addr);
    assign w_g_valid  = (state_q == ST_ISSUE);
    assign w_g_last   = w_g_valid && ({1'b0, rd_ptr_q} == (prog_len_q - c_len_one));
    assign w_g_fire   = w_g_valid && bus.g_ready;

    gate_mem #(
        .DEPTH (DEPTH),
        .GW    (c_gw)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_in_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_gate),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_rd_data)
    );

    // Loader sequencing: load, arm, issue, wait for done, hold status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            prog_len_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_early_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.clear) begin
                        wr_ptr_q <= '0;
                    end else if (w_in_fire) begin
                        if (bus.in_last || w_full) begin
                            // pointer is held here so it never wraps past DEPTH-1
                            prog_len_q <= {1'b0, wr_ptr_q} + c_len_one;
                            if (!bus.in_last) begin
                                err_ovf_q <= 1'b1;
                            end
                            state_q <= ST_ARM;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + c_ptr_one;
                        end
                    end
                end
                ST_ARM: begin
                    rd_ptr_q <= '0;
                    state_q  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.sched_done && !(w_g_fire && w_g_last)) begin
                        // scheduler finished before the final gate went out
                        err_early_q <= 1'b1;
                        state_q     <= ST_COMPLETE;
                    end else if (w_g_fire) begin
                        rd_ptr_q <= rd_ptr_q + c_ptr_one;
                        if (w_g_last) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.sched_done) begin
                        state_q <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    if (bus.clear) begin
                        wr_ptr_q    <= '0;
                        prog_len_q  <= '0;
                        err_ovf_q   <= 1'b0;
                        err_early_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.sched_start = (state_q == ST_ARM);
    assign bus.g_valid     = w_g_valid;
    assign bus.g_data      = w_g_valid ? w_rd_data : '0;
    assign bus.g_last      = w_g_last;
    assign bus.prog_len    = prog_len_q;
    assign bus.busy        = (state_q == ST_ARM) || (state_q == ST_ISSUE) ||
                             (state_q == ST_WAIT_DONE);
    assign bus.prog_done   = (state_q == ST_COMPLETE);
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_early   = err_early_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_loader
//  Description : Self-checking bench for gate_loader with directed scenarios
//                and randomized programs against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_loader;
    import qc_pkg::*;

    localparam int c_nq    = 4;
    localparam int c_depth = 32;
    localparam int c_gw    = calc_gw(c_nq);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gate_loader_if #(.N_QUBITS(c_nq), .DEPTH(c_depth)) bus ();

    gate_loader #(.N_QUBITS(c_nq), .DEPTH(c_depth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_total = 0;
    int              n_bad   = 0;
    logic [c_gw-1:0] prog_q[$];   // words the host offers
    logic [c_gw-1:0] exp_q[$];    // words the loader must later issue
    int              exp_len;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_prog(input int n);
        prog_q.delete();
        repeat (n) prog_q.push_back(c_gw'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"},    bus.in_ready,    0);
        check_val({tag, "_sched_start"}, bus.sched_start, 0);
        check_val({tag, "_g_valid"},     bus.g_valid,     0);
        check_val({tag, "_g_data"},      bus.g_data,      0);
        check_val({tag, "_g_last"},      bus.g_last,      0);
        check_val({tag, "_prog_len"},    bus.prog_len,    0);
        check_val({tag, "_busy"},        bus.busy,        0);
        check_val({tag, "_prog_done"},   bus.prog_done,   0);
        check_val({tag, "_err_ovf"},     bus.err_ovf,     0);
        check_val({tag, "_err_early"},   bus.err_early,   0);
    endtask

    // Offer prog_q (n words) with random gaps until the loader stops taking words
    task automatic load_prog(input int n, input bit with_last, input int valid_pct);
        int idx = 0;
        int cyc = 0;
        bit done = 0;
        bit exp_ovf;
        exp_q.delete();
        check_val("ld_in_ready", bus.in_ready, 1);
        while (!done) begin
            if (cyc > 3000) begin
                check_val("load_timeout", done, 1);
                break;
            end
            bus.clear      = 1'b0;
            bus.sched_done = 1'($urandom_range(1));
            if (idx < n && $urandom_range(99) < valid_pct) begin
                bus.in_valid = 1'b1;
                bus.in_gate  = prog_q[idx];
                bus.in_last  = with_last && (idx == n - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_gate  = c_gw'($urandom);
                bus.in_last  = 1'($urandom_range(1));
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(prog_q[idx]);
                idx++;
                if (bus.in_last || exp_q.size() == c_depth) done = 1;
            end
            step();
            cyc++;
        end
        // model: program is truncated at DEPTH, overflow when no last fits
        exp_len = (n < c_depth) ? n : c_depth;
        exp_ovf = !(with_last && n <= c_depth);
        check_val("acc_count",   exp_q.size(),    exp_len);
        check_val("sched_start", bus.sched_start, 1);
        check_val("arm_in_rdy",  bus.in_ready,    0);
        check_val("arm_busy",    bus.busy,        1);
        check_val("prog_len",    bus.prog_len,    exp_len);
        check_val("err_ovf",     bus.err_ovf,     exp_ovf);
        // keep offering any excess word; it must never be taken
        bus.in_valid = (idx < n);
        bus.in_gate  = (idx < n) ? prog_q[idx] : '0;
        bus.in_last  = 1'b0;
    endtask

    // Drain the program; use_pat selects g_ready pattern 1,0,0,1
    task automatic issue_prog(input int ready_pct, input bit use_pat, input int early_after);
        int              k = 0;
        int              cyc = 0;
        bit              ended = 0;
        bit              stalled = 0;
        logic [c_gw-1:0] prev = '0;
        bit [3:0]        pat = 4'b1001;
        step();
        check_val("first_gvalid", bus.g_valid,     1);
        check_val("start_pulse",  bus.sched_start, 0);
        while (!ended) begin
            if (cyc > 4000) begin
                check_val("issue_timeout", ended, 1);
                break;
            end
            if (early_after >= 0 && k == early_after) begin
                bus.g_ready    = 1'b0;
                bus.clear      = 1'b0;
                bus.sched_done = 1'b1;
                step();
                bus.sched_done = 1'b0;
                check_val("early_gvalid", bus.g_valid,   0);
                check_val("early_done",   bus.prog_done, 1);
                check_val("early_err",    bus.err_early, 1);
                check_val("early_busy",   bus.busy,      0);
                return;
            end
            check_val("g_valid", bus.g_valid, 1);
            check_val("g_data",  bus.g_data,  exp_q[k]);
            check_val("g_last",  bus.g_last,  (k == exp_len - 1));
            if (stalled) check_val("stall_hold", bus.g_data, prev);
            bus.sched_done = 1'b0;
            bus.clear      = 1'($urandom_range(1));
            bus.g_ready    = use_pat ? pat[cyc % 4] : ($urandom_range(99) < ready_pct);
            stalled        = bus.g_valid && !bus.g_ready;
            prev           = bus.g_data;
            if (bus.g_valid && bus.g_ready) begin
                k++;
                if (k == exp_len) ended = 1;
            end
            step();
            cyc++;
        end
        bus.clear = 1'b0;
        if (ready_pct == 100 && !use_pat) check_val("issue_cycles", cyc, exp_len);
        check_val("wait_gvalid", bus.g_valid,   0);
        check_val("wait_busy",   bus.busy,      1);
        check_val("wait_pdone",  bus.prog_done, 0);
    endtask

    task automatic finish_prog(input int delay);
        for (int d = 0; d < delay; d++) begin
            bus.clear      = 1'($urandom_range(1));
            bus.sched_done = 1'b0;
            step();
            check_val("wait_hold", bus.prog_done, 0);
            check_val("wait_busy2", bus.busy,     1);
        end
        bus.clear      = 1'b0;
        bus.sched_done = 1'b1;
        step();
        bus.sched_done = 1'b0;
        check_val("prog_done",  bus.prog_done, 1);
        check_val("done_busy",  bus.busy,      0);
        check_val("done_gval",  bus.g_valid,   0);
        step();
        check_val("done_hold",  bus.prog_done, 1);
    endtask

    task automatic clear_prog();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        step();
        bus.clear    = 1'b0;
        check_val("clr_pdone",    bus.prog_done, 0);
        check_val("clr_prog_len", bus.prog_len,  0);
        check_val("clr_ovf",      bus.err_ovf,   0);
        check_val("clr_early",    bus.err_early, 0);
        check_val("clr_busy",     bus.busy,      0);
        check_val("clr_in_ready", bus.in_ready,  1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gate_t g;
        int    n;
        int    early;
        bit    ovf_run;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_gate    = '0;
        bus.in_last    = 1'b0;
        bus.clear      = 1'b0;
        bus.g_ready    = 1'b0;
        bus.sched_done = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();
        check_val("post_rst_rdy", bus.in_ready, 1);

        // basic program: H q0, CNOT 0->1, X q2
        prog_q.delete();
        g = '{op: OP_H,    ctrl: 2'd0, tgt: 2'd0}; prog_q.push_back(g);
        g = '{op: OP_CNOT, ctrl: 2'd0, tgt: 2'd1}; prog_q.push_back(g);
        g = '{op: OP_X,    ctrl: 2'd0, tgt: 2'd2}; prog_q.push_back(g);
        load_prog(3, 1'b1, 100);
        issue_prog(100, 1'b0, -1);
        finish_prog(2);
        clear_prog();

        // backpressure 1,0,0,1
        make_prog(3);
        load_prog(3, 1'b1, 100);
        issue_prog(0, 1'b1, -1);
        finish_prog(1);
        clear_prog();

        // overflow: 33 words, no last
        make_prog(c_depth + 1);
        load_prog(c_depth + 1, 1'b0, 100);
        issue_prog(70, 1'b0, -1);
        finish_prog(0);
        clear_prog();

        // early done after the 2nd of 5 gates
        make_prog(5);
        load_prog(5, 1'b1, 100);
        issue_prog(100, 1'b0, 2);
        clear_prog();

        // clear during LOAD after 2 words, then a 1-gate program
        make_prog(2);
        for (int i = 0; i < 2; i++) begin
            check_val("pre_clr_rdy", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_gate  = prog_q[i];
            bus.in_last  = 1'b0;
            step();
        end
        bus.in_gate = c_gw'($urandom);
        bus.clear   = 1'b1;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        make_prog(1);
        load_prog(1, 1'b1, 100);
        issue_prog(100, 1'b0, -1);
        finish_prog(1);
        clear_prog();

        // reset during ISSUE
        make_prog(5);
        load_prog(5, 1'b1, 100);
        bus.in_valid = 1'b0;
        bus.g_ready  = 1'b0;
        step();
        check_val("pre_rst_gval", bus.g_valid, 1);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        check_val("rel_in_ready", bus.in_ready, 1);
        check_val("rel_busy",     bus.busy,     0);

        // randomized programs
        for (int r = 0; r < 10; r++) begin
            ovf_run = (r % 3 == 2);
            n = ovf_run ? c_depth + 1 + $urandom_range(2) : $urandom_range(c_depth, 1);
            make_prog(n);
            load_prog(n, !ovf_run, $urandom_range(100, 50));
            early = (r % 4 == 3) ? int'($urandom_range(exp_len - 1, 0)) : -1;
            issue_prog($urandom_range(100, 40), 1'b0, early);
            if (early < 0) finish_prog($urandom_range(3));
            clear_prog();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_loader.md
# gate_loader

Program buffer directly upstream of `scheduler` in the FPGA quantum-circuit core. Accepts a gate program from the host over a valid/ready stream and stores it locally. Pulses the scheduler's `start`, then streams the stored gates to the scheduler one per handshake. Waits for the scheduler's `done` and holds a completion status until the host clears it for the next program.

## Interface
- `N_QUBITS`, 4: qubit count. `QW = $clog2(N_QUBITS)` is the qubit index width.
- `DEPTH`, 32: maximum gates per program (power of 2, ≥2).
- `GW`, 4+2*QW: gate word width, `{opcode[3:0], ctrl[QW-1:0], tgt[QW-1:0]}`.
- Ports:
  - `clk` in 1: single clock.
  - `rst` in 1: synchronous, active-high reset.
  - `in_valid` in 1: host gate word valid.
  - `in_ready` out 1: loader can accept a gate word.
  - `in_gate` in GW: gate word.
  - `in_last` in 1: last gate of the program.
  - `clear` in 1: discard a partial program, or re-arm after completion.
  - `sched_start` out 1: one-cycle start pulse to the scheduler.
  - `g_valid` out 1: gate valid toward the scheduler.
  - `g_ready` in 1: scheduler accepts the gate.
  - `g_data` out GW: gate word.
  - `g_last` out 1: final gate of the program.
  - `sched_done` in 1: scheduler done, level.
  - `prog_len` out $clog2(DEPTH)+1: gates in the loaded program.
  - `busy` out 1: state is ARM, ISSUE or WAIT_DONE.
  - `prog_done` out 1: program completed.
  - `err_ovf` out 1: sticky; program truncated at DEPTH.
  - `err_early` out 1: sticky; `sched_done` arrived before the last gate was issued.

## Operation
- **States**:
  - LOAD: accept gate words.
  - ARM: pulse start.
  - ISSUE: stream gates.
  - WAIT_DONE: wait for the scheduler.
  - COMPLETE: hold status.
- **LOAD**
  - `in_ready`=1.
  - On `in_valid && in_ready`: write `mem[wr_ptr]` and increment `wr_ptr`.
  - If `in_last`=1, or `wr_ptr==DEPTH-1` (buffer now full): set `prog_len=wr_ptr+1` and go to ARM.
  - Full without `in_last`: set `err_ovf`, truncate the program, still go to ARM.
  - `clear` in LOAD: `wr_ptr`←0; any word offered in the same cycle is dropped (clear wins).
- **ARM**
  - `sched_start`=1 for exactly this cycle.
  - `rd_ptr`←0, then go to ISSUE.
- **ISSUE**
  - `g_valid`=1; `g_data=mem[rd_ptr]` (combinational read); `g_last=(rd_ptr==prog_len-1)`.
  - On handshake: `rd_ptr++`.
  - If the handshake occurs with `g_last`=1, go to WAIT_DONE.
  - `g_data` and `g_last` must stay stable while `g_valid && !g_ready`.
- **WAIT_DONE**
  - On `sched_done`=1, go to COMPLETE.
- **COMPLETE**
  - `prog_done`=1.
  - On `clear`: go to LOAD and clear `wr_ptr`, `prog_len`, `err_ovf`, `err_early`, `prog_done`.
- **Early done**: `sched_done` seen in ISSUE sets `err_early`, goes to COMPLETE, and drops `g_valid` the next cycle.
- **Ignored events**:
  - `sched_done` in LOAD or ARM is ignored.
  - `clear` in ARM, ISSUE or WAIT_DONE is ignored.
- **Widths**:
  - Pointers are $clog2(DEPTH) bits.
  - `prog_len` is one bit wider so that DEPTH is representable.
  - No wrap: `wr_ptr` never passes DEPTH-1.
- Zero-length programs cannot occur; minimum length is 1.

## Timing
- **Reset values**: state=LOAD, `in_ready`=0, `sched_start`=0, `g_valid`=0, `g_data`=0, `g_last`=0, `prog_len`=0, `busy`=0, `prog_done`=0, `err_ovf`=0, `err_early`=0.
- `in_ready` is gated low during `rst`. In the first cycle after `rst` deasserts, `in_ready`=1.
- **Latencies**:
  - Last word accepted at cycle T → `sched_start` at T+1.
  - First `g_valid` at T+2.
- **Throughput**: one gate per cycle when `g_ready` is held high. A program of N gates finishes issuing at T+1+N.
- **Completion**: `prog_done` rises the cycle after `sched_done` is sampled in WAIT_DONE.
- **Reset mid-run**: returns to LOAD immediately, the program is lost, and all outputs take their reset values next cycle.

## Structure
- Shared package `qc_pkg`:
  - `gate_op_e` (4-bit opcode: I, X, Y, Z, H, S, T, CNOT).
  - packed `gate_t {op, ctrl, tgt}`.
  - `loader_state_e`.
  - `GW` and `QW` helper functions.
  - `scheduler` is to import the same `gate_t`.
- Sub-module `gate_mem`:
  - DEPTH×GW register array.
  - One synchronous write port, one asynchronous read port.
  - No reset on the array contents.

## Test plan
- **Basic program**: load 3 gates {H q0, CNOT 0→1, X q2}, last flagged on the 3rd, `g_ready`=1.
  - `sched_start` one cycle after the 3rd accept.
  - Gates appear on consecutive cycles, `g_last` on the 3rd.
  - `prog_len`=3.
  - `sched_done` → `prog_done`=1.
- **Backpressure**: `g_ready` toggling 1,0,0,1.
  - `g_data` stable while stalled.
  - Exactly 3 handshakes, in order.
- **Overflow**: 33 words with `DEPTH`=32 and no `in_last`.
  - `err_ovf`=1, `prog_len`=32.
  - `in_ready`=0 after the 32nd word.
  - The 33rd word is never accepted.
- **Early done**: `sched_done`=1 after the 2nd of 5 gates.
  - `err_early`=1, state COMPLETE, `g_valid`=0 next cycle.
- **Clear and reset**:
  - `clear` during LOAD after 2 words: `wr_ptr`=0; a new 1-gate program issues correctly.
  - `rst` during ISSUE: all outputs at reset values; `in_ready`=1 the cycle after release.
